// File: rtl/stream_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_mem_arbiter
// Purpose  : Shares one streaming memory port among NumReq requesters.
//            Arbitration, bounded outstanding requests (credits) and
//            in-order response routing back to the issuing requester.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   mem_req_t       request payload type (passed through unchanged)
//   mem_resp_t      response payload type
//   NumReq          number of requesters (>= 1)
//   MaxOutstanding  max issued-but-undelivered requests (>= 1)
// Ports
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   req_i/req_valid_i/req_ready_o      per-requester request streams
//   resp_o/resp_valid_o/resp_ready_i   shared response payload, one-hot valid
//   mem_req_o/_valid_o/_ready_i        request stream toward memory
//   mem_resp_i/mem_resp_valid_i        in-order memory responses, no ready
// Build option
//   STREAM_MEM_ARBITER_RR_EN  defined   : round-robin arbitration
//                             undefined : fixed priority, lowest index wins
// ============================================================================
module stream_mem_arbiter #(
    parameter type         mem_req_t      = logic,
    parameter type         mem_resp_t     = logic,
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  mem_req_t            req_i [NumReq],
    input  logic [NumReq-1:0]   req_valid_i,
    output logic [NumReq-1:0]   req_ready_o,
    output mem_resp_t           resp_o,
    output logic [NumReq-1:0]   resp_valid_o,
    input  logic [NumReq-1:0]   resp_ready_i,
    output mem_req_t            mem_req_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    input  mem_resp_t           mem_resp_i,
    input  logic                mem_resp_valid_i
);

    localparam int unsigned c_cnt_w = $clog2(MaxOutstanding + 1) + 1;
    localparam int unsigned c_idx_w = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned c_ptr_w = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    localparam logic [c_cnt_w-1:0] c_max      = c_cnt_w'(MaxOutstanding);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(MaxOutstanding - 1);

    typedef logic [c_idx_w-1:0] idx_t;
    typedef logic [c_ptr_w-1:0] ptr_t;
    typedef logic [c_cnt_w-1:0] cnt_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // r_cnt is both the credit counter and the ID FIFO occupancy: an ID is
    // pushed on every issue and popped on every delivery.
    cnt_t       r_cnt;
    logic       r_locked;
    idx_t       r_lock_idx;
`ifdef STREAM_MEM_ARBITER_RR_EN
    idx_t       r_rr_ptr;
`endif

    idx_t       r_id_mem [MaxOutstanding];
    ptr_t       r_id_wr;
    ptr_t       r_id_rd;

    mem_resp_t  r_resp_mem [MaxOutstanding];
    ptr_t       r_resp_wr;
    ptr_t       r_resp_rd;
    cnt_t       r_resp_cnt;

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    logic       w_resp_buffered;
    logic       w_resp_vld;
    logic       w_resp_hs;
    logic       w_resp_push;
    logic       w_resp_pop;
    idx_t       w_id_head;

    assign w_resp_buffered = (r_resp_cnt != '0);
    assign w_id_head       = r_id_mem[r_id_rd];
    // Fall-through: with nothing buffered the live memory response is the head.
    assign resp_o          = w_resp_buffered ? r_resp_mem[r_resp_rd] : mem_resp_i;
    assign w_resp_vld      = rst_ni & (r_cnt != '0) & (w_resp_buffered | mem_resp_valid_i);
    assign w_resp_hs       = w_resp_vld & resp_ready_i[w_id_head];
    // A response consumed in its arrival cycle never enters the buffer.
    assign w_resp_push     = rst_ni & mem_resp_valid_i & ~(w_resp_hs & ~w_resp_buffered);
    assign w_resp_pop      = w_resp_hs & w_resp_buffered;

    always_comb begin
        resp_valid_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            resp_valid_o[i] = w_resp_vld & (w_id_head == idx_t'(i));
        end
    end

    // ------------------------------------------------------------------
    // Request arbitration
    // ------------------------------------------------------------------
    logic       w_issue_ok;
    logic       w_found;
    idx_t       w_grant;
    logic       w_mem_hs;

    // A delivery this cycle frees a credit that may be reused immediately.
    assign w_issue_ok = (r_cnt < c_max) | w_resp_hs;

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        if (r_locked) begin
            w_grant = r_lock_idx;
            w_found = req_valid_i[r_lock_idx];
        end else begin
`ifdef STREAM_MEM_ARBITER_RR_EN
            for (int unsigned i = 0; i < NumReq; i++) begin
                int unsigned idx;
                idx = (32'(r_rr_ptr) + 1 + i) % NumReq;
                if (!w_found && req_valid_i[idx_t'(idx)]) begin
                    w_grant = idx_t'(idx);
                    w_found = 1'b1;
                end
            end
`else
            for (int i = NumReq - 1; i >= 0; i--) begin
                if (req_valid_i[idx_t'(i)]) begin
                    w_grant = idx_t'(i);
                    w_found = 1'b1;
                end
            end
`endif
        end
    end

    assign mem_req_o       = req_i[w_grant];
    assign mem_req_valid_o = rst_ni & w_issue_ok & w_found;
    assign w_mem_hs        = mem_req_valid_o & mem_req_ready_i;

    always_comb begin
        req_ready_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            req_ready_o[i] = mem_req_valid_o & mem_req_ready_i & (w_grant == idx_t'(i));
        end
    end

    // ------------------------------------------------------------------
    // Sequential control
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
`ifdef STREAM_MEM_ARBITER_RR_EN
            r_rr_ptr   <= idx_t'(NumReq - 1);
`endif
            r_id_wr    <= '0;
            r_id_rd    <= '0;
            r_resp_wr  <= '0;
            r_resp_rd  <= '0;
            r_resp_cnt <= '0;
        end else begin
            // Hold the grant while the memory stalls so the request stream
            // stays stable even if a higher-priority requester shows up.
            if (w_mem_hs) begin
                r_locked <= 1'b0;
                r_id_wr  <= ptr_inc(r_id_wr);
`ifdef STREAM_MEM_ARBITER_RR_EN
                r_rr_ptr <= w_grant;
`endif
            end else if (mem_req_valid_o) begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_grant;
            end

            if (w_resp_hs) begin
                r_id_rd <= ptr_inc(r_id_rd);
            end

            case ({w_mem_hs, w_resp_hs})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            if (w_resp_push) begin
                r_resp_wr <= ptr_inc(r_resp_wr);
            end
            if (w_resp_pop) begin
                r_resp_rd <= ptr_inc(r_resp_rd);
            end

            case ({w_resp_push, w_resp_pop})
                2'b10:   r_resp_cnt <= r_resp_cnt + 1'b1;
                2'b01:   r_resp_cnt <= r_resp_cnt - 1'b1;
                default: r_resp_cnt <= r_resp_cnt;
            endcase
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_mem_hs) begin
            r_id_mem[r_id_wr] <= w_grant;
        end
        if (w_resp_push) begin
            r_resp_mem[r_resp_wr] <= mem_resp_i;
        end
    end

`ifndef SYNTHESIS
    // A response with no outstanding request, or into a full buffer, means
    // the memory broke the in-order / one-response-per-request contract.
    a_resp_protocol : assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_resp_valid_i |-> ((r_resp_cnt < c_max) && (r_cnt != '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mem_arbiter
// Purpose  : Randomized self-checking bench for stream_mem_arbiter against a
//            queue-based reference model (3 requesters, 4 credits, 8-bit data).
// Revision : 1.0  initial release
// Build option honoured: STREAM_MEM_ARBITER_RR_EN (selects expected priority)
// ============================================================================
module tb_stream_mem_arbiter;

    localparam int NREQ = 3;
    localparam int MAXO = 4;

    typedef logic [7:0] byte_t;
    typedef struct {
        byte_t data;
        int    due;
    } pend_t;

    logic            clk = 1'b0;
    logic            rst_n;
    byte_t           req [NREQ];
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    byte_t           resp;
    logic [NREQ-1:0] resp_valid;
    logic [NREQ-1:0] resp_ready;
    byte_t           mem_req;
    logic            mem_req_valid;
    logic            mem_req_ready;
    byte_t           mem_resp;
    logic            mem_resp_valid;

    always #5 clk = ~clk;

    stream_mem_arbiter #(
        .mem_req_t      (byte_t),
        .mem_resp_t     (byte_t),
        .NumReq         (NREQ),
        .MaxOutstanding (MAXO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_i            (req),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .resp_o           (resp),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .mem_req_o        (mem_req),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_resp_i       (mem_resp),
        .mem_resp_valid_i (mem_resp_valid)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int    id_q [$];          // requester index of each outstanding request
    byte_t resp_q [$];        // responses absorbed but not yet delivered
    byte_t sent_q [NREQ][$];  // per-requester issued payloads, in order
    pend_t mem_q [$];         // memory model: accepted requests awaiting reply
    int    rr   = NREQ - 1;
    int    lock = -1;
    bit    busy [NREQ];       // requester holds valid until accepted
    int    cyc  = 0;
    int    hs_count = 0;

    // stimulus knobs
    int pv = 50, pm = 70, pr = 70;
    bit hold_resp = 1'b0;
    int stall_req = -1;

    function automatic byte_t mem_fn(input byte_t d);
        return d ^ 8'h3C;
    endfunction

    task automatic model_reset();
        id_q.delete();
        resp_q.delete();
        mem_q.delete();
        for (int r = 0; r < NREQ; r++) sent_q[r].delete();
        rr   = NREQ - 1;
        lock = -1;
    endtask

    task automatic step(input bit rst_val);
        int    g;
        int    rv;
        bit    found;
        bit    ok;
        bit    ev;
        bit    rhs;
        bit    mhs;
        byte_t er;

        @(negedge clk);
        rst_n = rst_val;
        for (int r = 0; r < NREQ; r++) begin
            if (!busy[r]) begin
                req_valid[r] = ($urandom_range(99) < pv);
                req[r]       = byte_t'($urandom);
            end
            resp_ready[r] = (r != stall_req) && ($urandom_range(99) < pr);
        end
        mem_req_ready  = ($urandom_range(99) < pm);
        mem_resp_valid = 1'b0;
        mem_resp       = byte_t'($urandom);
        if (rst_val && !hold_resp && mem_q.size() > 0 && mem_q[0].due <= cyc &&
            $urandom_range(99) < 70) begin
            mem_resp_valid = 1'b1;
            mem_resp       = mem_q[0].data;
        end
        #1;

        if (!rst_val) begin
            check("rst_mem_req_valid", 32'(mem_req_valid), 0);
            check("rst_req_ready",     32'(req_ready), 0);
            check("rst_resp_valid",    32'(resp_valid), 0);
            @(posedge clk);
            model_reset();
            cyc++;
            return;
        end

        // expected response side
        rv = -1;
        if (id_q.size() > 0 && (resp_q.size() > 0 || mem_resp_valid)) rv = id_q[0];
        er  = (resp_q.size() > 0) ? resp_q[0] : mem_resp;
        rhs = (rv >= 0) && resp_ready[rv];

        // expected request side
        ok    = (id_q.size() < MAXO) || rhs;
        g     = 0;
        found = 1'b0;
        if (lock >= 0) begin
            g     = lock;
            found = req_valid[lock];
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                int idx;
`ifdef STREAM_MEM_ARBITER_RR_EN
                idx = (rr + 1 + i) % NREQ;
`else
                idx = i;
`endif
                if (!found && req_valid[idx]) begin
                    g     = idx;
                    found = 1'b1;
                end
            end
        end
        ev  = ok && found;
        mhs = ev && mem_req_ready;

        check("mem_req_valid", 32'(mem_req_valid), 32'(ev));
        if (ev) check("mem_req", 32'(mem_req), 32'(req[g]));
        check("req_ready", 32'(req_ready), mhs ? (32'd1 << g) : 32'd0);
        check("resp_valid", 32'(resp_valid), (rv >= 0) ? (32'd1 << rv) : 32'd0);
        if (rv >= 0) check("resp_data", 32'(resp), 32'(er));
        if (rhs) begin
            if (sent_q[rv].size() > 0) check("route", 32'(resp), 32'(mem_fn(sent_q[rv][0])));
            else                       check("route_empty", 32'(resp), 32'hFFFF_FFFF);
        end

        @(posedge clk);
        if (mem_resp_valid) void'(mem_q.pop_front());
        if (rhs) begin
            void'(id_q.pop_front());
            if (sent_q[rv].size() > 0) void'(sent_q[rv].pop_front());
            if (resp_q.size() > 0) begin
                void'(resp_q.pop_front());
                if (mem_resp_valid) resp_q.push_back(mem_resp);
            end
        end else if (mem_resp_valid) begin
            resp_q.push_back(mem_resp);
        end
        if (mhs) begin
            id_q.push_back(g);
            sent_q[g].push_back(req[g]);
            mem_q.push_back('{data: mem_fn(req[g]), due: cyc + 1 + int'($urandom_range(2))});
            rr   = g;
            lock = -1;
            hs_count++;
        end else if (ev) begin
            lock = g;
        end
        for (int r = 0; r < NREQ; r++) busy[r] = req_valid[r] && !(mhs && g == r);
        cyc++;
    endtask

    task automatic drain();
        pv = 0; pr = 100; pm = 100; hold_resp = 1'b0; stall_req = -1;
        for (int k = 0; k < 500 && (id_q.size() > 0 || busy[0] || busy[1] || busy[2]); k++) step(1);
        check("drain_outstanding", 32'(id_q.size()), 0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int base;
        rst_n          = 1'b0;
        req_valid      = '0;
        resp_ready     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp       = '0;
        for (int r = 0; r < NREQ; r++) begin
            req[r]  = '0;
            busy[r] = 1'b0;
        end

        pv = 0;
        step(0);
        step(0);

        // mixed random traffic
        pv = 60; pm = 70; pr = 70;
        for (int k = 0; k < 1500; k++) step(1);

        // saturated: arbitration order under continuous demand
        pv = 100; pm = 100; pr = 100;
        for (int k = 0; k < 200; k++) step(1);

        // slow memory: exercises the grant lock
        pv = 70; pm = 30; pr = 80;
        for (int k = 0; k < 500; k++) step(1);

        // one requester refuses responses: head-of-line blocking
        pv = 60; pm = 80; pr = 80; stall_req = 1;
        for (int k = 0; k < 100; k++) step(1);
        stall_req = -1;
        for (int k = 0; k < 100; k++) step(1);

        // credit limit: memory withholds replies
        drain();
        pv = 100; pm = 100; pr = 100; hold_resp = 1'b1;
        base = hs_count;
        for (int k = 0; k < 10; k++) step(1);
        check("credit_limit_issues", 32'(hs_count - base), 32'(MAXO));
        #1;
        check("credit_stall_valid", 32'(mem_req_valid), 0);
        hold_resp = 1'b0;
        for (int k = 0; k < 30; k++) step(1);

        // reset with requests in flight
        drain();
        pv = 100; pm = 100; pr = 100; hold_resp = 1'b1;
        for (int k = 0; k < 20 && id_q.size() < 3; k++) step(1);
        step(0);
        hold_resp = 1'b0;
        for (int k = 0; k < 200; k++) step(1);

        // final random burst and drain
        pv = 50; pm = 60; pr = 60;
        for (int k = 0; k < 500; k++) step(1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
